// File: rtl/sequence_management_pkg.sv
// Shared definitions for the sequence insertion controller.
// Holds the FSM state encoding, default timing constants and small helper
// functions used by the controller and its staging buffer.
package sequence_management_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_ARM   = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SHIFT = 3'd4
    } state_t;

    localparam int DEF_INSERT_LINE      = 21;
    localparam int DEF_SAMPLES_PER_LINE = 1440;
    localparam int DEF_LOAD_HOLD        = 36;

    localparam int SEQ_W      = 32;
    localparam int LINE_W     = 11;
    localparam int FIELD_BOTH = 2;

    // Line counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [LINE_W-1:0] line_inc_sat(input logic [LINE_W-1:0] line);
        return (line == '1) ? line : line + 1'b1;
    endfunction

    // True when the given field takes part in insertion for this field selection.
    function automatic logic field_selected(input int field_sel, input logic field);
        if (field_sel == FIELD_BOTH) begin
            return 1'b1;
        end
        return field == field_sel[0];
    endfunction

endpackage

// File: rtl/sequence_stage_buffer.sv
// One-entry staging register in front of the active sequence register.
// Ports:
//   clock, rst_n  : sample clock, asynchronous active-low reset
//   seq_valid     : upstream offers seq_data
//   seq_data      : next sequence word
//   swap          : field boundary; staged word (if any) becomes active
//   seq_ready     : staging slot empty
//   active        : sequence currently presented to the generator
module sequence_stage_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              seq_valid,
    input  logic [DATA_W-1:0] seq_data,
    input  logic              swap,
    output logic              seq_ready,
    output logic [DATA_W-1:0] active
);

    logic              full;
    logic [DATA_W-1:0] staging;
    logic              take;

    // A swap vacates a full slot in the same cycle, so an offered word is
    // taken then even though seq_ready showed the slot as occupied.
    assign take      = seq_valid & (~full | swap);
    assign seq_ready = ~full;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            active <= '0;
        end else begin
            if (swap && full) begin
                active <= staging;
            end
            if (take) begin
                full <= 1'b1;
            end else if (swap) begin
                full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (take) begin
            staging <= seq_data;
        end
    end

endmodule

// File: rtl/sequence_insert_controller.sv
// Inserts a 32-bit scrambler sequence on one selected line of each field.
// Counts lines after vsync, waits for active video on the insert line, then
// loads the generator for LOAD_HOLD clocks and runs it for SAMPLES_PER_LINE.
// Ports:
//   clock, rst_n       : sample clock, asynchronous active-low reset
//   hsync, vsync       : one-cycle line / field start pulses
//   field_id           : field identifier, sampled at vsync
//   avid               : active video flag
//   seq_valid/seq_data : upstream sequence offer, seq_ready = staging empty
//   gen_sequence       : active sequence for the generator
//   gen_load           : generator shift-register load
//   gen_enable         : generator enable (low holds it in reset)
//   insert_done        : pulse when an insertion completes
//   sync_error         : pulse when an insertion is aborted
module sequence_insert_controller
    import sequence_management_pkg::*;
#(
    parameter int INSERT_LINE      = DEF_INSERT_LINE,
    parameter int SAMPLES_PER_LINE = DEF_SAMPLES_PER_LINE,
    parameter int LOAD_HOLD        = DEF_LOAD_HOLD,
    parameter int FIELD_SEL        = FIELD_BOTH
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             field_id,
    input  logic             avid,
    input  logic             seq_valid,
    input  logic [SEQ_W-1:0] seq_data,
    output logic             seq_ready,
    output logic [SEQ_W-1:0] gen_sequence,
    output logic             gen_load,
    output logic             gen_enable,
    output logic             insert_done,
    output logic             sync_error
);

    localparam int CNT_MAX = (LOAD_HOLD > SAMPLES_PER_LINE) ? LOAD_HOLD : SAMPLES_PER_LINE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state, state_next;
    logic [LINE_W-1:0] line_cnt, line_next;
    logic [CNT_W-1:0]  sample_cnt;
    logic              field_q;
    logic              running;
    logic              vsync_ok;
    logic              done_evt, err_evt;

    // The first edge after reset release only sets running, so a vsync
    // coinciding with that edge is ignored.
    assign vsync_ok = vsync & running;

    sequence_stage_buffer #(.DATA_W(SEQ_W)) u_stage (
        .clock     (clock),
        .rst_n     (rst_n),
        .seq_valid (seq_valid),
        .seq_data  (seq_data),
        .swap      (vsync_ok),
        .seq_ready (seq_ready),
        .active    (gen_sequence)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            line_cnt    <= '0;
            sample_cnt  <= '0;
            field_q     <= 1'b0;
            running     <= 1'b0;
            insert_done <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            running     <= 1'b1;
            state       <= state_next;
            line_cnt    <= line_next;
            insert_done <= done_evt;
            sync_error  <= err_evt;
            if (vsync_ok) begin
                field_q <= field_id;
            end
            // Restart on every state change; only LOAD and SHIFT consume it.
            if (state_next != state || !(state_next == ST_LOAD || state_next == ST_SHIFT)) begin
                sample_cnt <= '0;
            end else begin
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        line_next  = line_cnt;
        done_evt   = 1'b0;
        err_evt    = 1'b0;
        if (vsync_ok) begin
            // Field start outranks everything, including a same-cycle hsync.
            line_next = '0;
            if (state == ST_LOAD || state == ST_SHIFT) begin
                err_evt = 1'b1;
            end
            if (!field_selected(FIELD_SEL, field_id)) begin
                state_next = ST_IDLE;
            end else if (INSERT_LINE == 0) begin
                state_next = ST_ARM;
            end else begin
                state_next = ST_COUNT;
            end
        end else begin
            unique case (state)
                ST_COUNT: begin
                    if (hsync) begin
                        line_next = line_inc_sat(line_cnt);
                        if (line_next == LINE_W'(INSERT_LINE) && field_selected(FIELD_SEL, field_q)) begin
                            state_next = ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    if (hsync) begin
                        state_next = ST_IDLE;
                        err_evt    = 1'b1;
                    end else if (avid) begin
                        state_next = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (sample_cnt == CNT_W'(LOAD_HOLD - 1)) begin
                        state_next = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sample_cnt == CNT_W'(SAMPLES_PER_LINE - 1)) begin
                        state_next = ST_IDLE;
                        done_evt   = 1'b1;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        gen_load   = 1'b0;
        gen_enable = 1'b0;
        case (state)
            ST_LOAD: begin
                gen_load   = 1'b1;
                gen_enable = 1'b1;
            end
            ST_SHIFT: gen_enable = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sequence_insert_controller.sv
// Directed and randomized bench for sequence_insert_controller.
// DUT a uses both fields, DUT b selects field 0 only; both share inputs.
module tb_sequence_insert_controller;

    localparam int LOAD_C = 36;
    localparam int SPL_C  = 1440;

    logic        clock = 1'b0;
    logic        rst_n, hsync, vsync, field_id, avid, seq_valid;
    logic [31:0] seq_data;

    logic        a_ready, a_load, a_en, a_done, a_err;
    logic [31:0] a_seq;
    logic        b_ready, b_load, b_en, b_done, b_err;
    logic [31:0] b_seq;

    always #5 clock = ~clock;

    sequence_insert_controller #(.FIELD_SEL(2)) dut_a (
        .clock(clock), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .field_id(field_id), .avid(avid), .seq_valid(seq_valid), .seq_data(seq_data),
        .seq_ready(a_ready), .gen_sequence(a_seq), .gen_load(a_load),
        .gen_enable(a_en), .insert_done(a_done), .sync_error(a_err)
    );

    sequence_insert_controller #(.FIELD_SEL(0)) dut_b (
        .clock(clock), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .field_id(field_id), .avid(avid), .seq_valid(seq_valid), .seq_data(seq_data),
        .seq_ready(b_ready), .gen_sequence(b_seq), .gen_load(b_load),
        .gen_enable(b_en), .insert_done(b_done), .sync_error(b_err)
    );

    // Cumulative activity counters, sampled mid-cycle.
    int mon_load = 0, mon_en = 0, mon_done = 0, mon_err = 0, mon_b_en = 0;
    always @(negedge clock) begin
        if (a_load === 1'b1) mon_load <= mon_load + 1;
        if (a_en   === 1'b1) mon_en   <= mon_en + 1;
        if (a_done === 1'b1) mon_done <= mon_done + 1;
        if (a_err  === 1'b1) mon_err  <= mon_err + 1;
        if (b_en   === 1'b1) mon_b_en <= mon_b_en + 1;
    end

    int checks = 0;
    int errors = 0;

    // Reference model of the sequence path: one staging slot plus active word.
    logic        m_full = 1'b0;
    logic [31:0] m_stage = 32'h0;
    logic [31:0] m_active = 32'h0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check32(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_vsync(input logic fid, input logic sv, input logic [31:0] sd);
        vsync = 1'b1; field_id = fid; seq_valid = sv; seq_data = sd;
        if (m_full) begin
            m_active = m_stage;
            m_full   = 1'b0;
        end
        if (sv) begin
            m_stage = sd;
            m_full  = 1'b1;
        end
        step();
        vsync = 1'b0; seq_valid = 1'b0;
    endtask

    task automatic offer(input logic [31:0] sd);
        seq_valid = 1'b1; seq_data = sd;
        if (!m_full) begin
            m_stage = sd;
            m_full  = 1'b1;
        end
        step();
        seq_valid = 1'b0;
    endtask

    task automatic do_hsync();
        hsync = 1'b1;
        step();
        hsync = 1'b0;
    endtask

    task automatic lines(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            do_hsync();
            repeat (gap) step();
        end
    endtask

    task automatic avid_pulse();
        avid = 1'b1;
        step();
        avid = 1'b0;
    endtask

    // Counts load/enable cycles from the current sample until enable drops.
    task automatic measure(output int load_c, output int en_c, output logic done_end);
        int guard;
        load_c = 0; en_c = 0; guard = 0;
        while (a_en === 1'b1 && guard < 3000) begin
            if (a_load === 1'b1) load_c++;
            en_c++;
            guard++;
            step();
        end
        done_end = a_done;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc, ec, snap_load, snap_en, snap_err, snap_done, snap_b;
        logic de;
        int fid, mode, k;
        logic [31:0] w;

        rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0; field_id = 1'b0;
        avid = 1'b0; seq_valid = 1'b0; seq_data = 32'h0;
        repeat (3) step();

        check1 ("rst_ready", a_ready, 1'b1);
        check32("rst_seq",   a_seq,   32'h0);
        check1 ("rst_load",  a_load,  1'b0);
        check1 ("rst_en",    a_en,    1'b0);
        check1 ("rst_done",  a_done,  1'b0);
        check1 ("rst_err",   a_err,   1'b0);

        // vsync on the reset-exit edge must be ignored: no insertion follows.
        @(negedge clock);
        rst_n = 1'b1; vsync = 1'b1;
        step();
        vsync = 1'b0;
        snap_load = mon_load;
        lines(21, 1);
        avid_pulse();
        repeat (3) step();
        check32("exit_vsync_ignored", 32'(mon_load - snap_load), 32'h0);

        // Full line insertion with DEADBEEF.
        offer(32'hDEADBEEF);
        check1 ("stage_full_ready", a_ready, 1'b0);
        do_vsync(1'b0, 1'b0, 32'h0);
        check32("seq_deadbeef", a_seq, 32'hDEADBEEF);
        check1 ("ready_after_swap", a_ready, 1'b1);
        lines(21, 2);
        repeat (3) step();
        check1 ("arm_no_load", a_load, 1'b0);
        snap_b = mon_b_en; snap_done = mon_done;
        avid_pulse();
        check1 ("load_first", a_load, 1'b1);
        check1 ("en_first",   a_en,   1'b1);
        measure(lc, ec, de);
        check32("load_cycles", 32'(lc), 32'(LOAD_C));
        check32("en_cycles",   32'(ec), 32'(LOAD_C + SPL_C));
        check1 ("done_with_en_low", de, 1'b1);
        step();
        check1 ("done_one_pulse", a_done, 1'b0);
        check32("done_count", 32'(mon_done - snap_done), 32'h1);
        check32("b_field0_en", 32'(mon_b_en - snap_b), 32'(LOAD_C + SPL_C));
        check32("seq_stable", a_seq, 32'hDEADBEEF);

        // vsync in SHIFT clock 700 aborts; line counting restarts.
        do_vsync(1'b0, 1'b0, 32'h0);
        lines(21, 1);
        snap_en = mon_en; snap_err = mon_err;
        avid_pulse();
        repeat (LOAD_C + 700 - 1) step();
        do_vsync(1'b0, 1'b0, 32'h0);
        check1 ("abort_en_low",  a_en,  1'b0);
        check1 ("abort_err",     a_err, 1'b1);
        check32("abort_en_cycles", 32'(mon_en - snap_en), 32'(LOAD_C + 700));
        step();
        check1 ("abort_err_pulse", a_err, 1'b0);
        check32("abort_err_count", 32'(mon_err - snap_err), 32'h1);
        snap_load = mon_load;
        lines(20, 1);
        avid = 1'b1; repeat (3) step(); avid = 1'b0;
        check32("line20_no_load", 32'(mon_load - snap_load), 32'h0);
        do_hsync();
        avid_pulse();
        check1 ("line21_load", a_load, 1'b1);
        measure(lc, ec, de);
        check32("reins_load_cycles", 32'(lc), 32'(LOAD_C));

        // hsync in ARM aborts.
        do_vsync(1'b0, 1'b0, 32'h0);
        lines(21, 1);
        snap_load = mon_load; snap_err = mon_err;
        do_hsync();
        check1 ("arm_abort_err", a_err, 1'b1);
        avid = 1'b1; repeat (4) step(); avid = 1'b0;
        check32("arm_abort_no_load", 32'(mon_load - snap_load), 32'h0);
        check32("arm_abort_err_count", 32'(mon_err - snap_err), 32'h1);

        // Staging behaviour around vsync.
        offer(32'h1);
        check1 ("stage1_ready", a_ready, 1'b0);
        do_vsync(1'b0, 1'b1, 32'h2);
        check32("swap_pre_contents", a_seq, 32'h1);
        check1 ("swap_ready_low", a_ready, 1'b0);
        do_vsync(1'b0, 1'b0, 32'h0);
        check32("staged_word2", a_seq, 32'h2);
        check1 ("ready_empty", a_ready, 1'b1);
        do_vsync(1'b0, 1'b0, 32'h0);
        check32("empty_hold", a_seq, 32'h2);
        do_vsync(1'b0, 1'b1, 32'h3);
        check32("empty_xfer_hold", a_seq, 32'h2);
        check1 ("empty_xfer_ready", a_ready, 1'b0);
        do_vsync(1'b0, 1'b0, 32'h0);
        check32("xfer_word3", a_seq, 32'h3);

        // Field 1: a inserts, b (field 0 only) stays idle.
        do_vsync(1'b1, 1'b0, 32'h0);
        snap_b = mon_b_en;
        lines(21, 1);
        avid_pulse();
        check1 ("f1_a_load", a_load, 1'b1);
        measure(lc, ec, de);
        repeat (5) step();
        check32("f1_b_no_en", 32'(mon_b_en - snap_b), 32'h0);

        // Randomized fields against the reference model.
        for (int it = 0; it < 5; it++) begin
            fid = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                w = $urandom;
                offer(w);
                check1("rnd_ready_offer", a_ready, ~m_full);
            end
            w = $urandom;
            do_vsync(fid[0], logic'($urandom_range(0, 1)), w);
            check32("rnd_seq", a_seq, m_active);
            check1 ("rnd_ready", a_ready, ~m_full);
            snap_load = mon_load; snap_en = mon_en; snap_err = mon_err;
            snap_done = mon_done; snap_b = mon_b_en;
            lines(21, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 5)) step();
            mode = int'($urandom_range(0, 2));
            if (mode == 1) begin
                do_hsync();
                avid_pulse();
                repeat (3) step();
                check32("rnd_hs_load", 32'(mon_load - snap_load), 32'h0);
                check32("rnd_hs_err",  32'(mon_err - snap_err), 32'h1);
                check32("rnd_hs_b",    32'(mon_b_en - snap_b), 32'h0);
            end else if (mode == 0) begin
                avid_pulse();
                measure(lc, ec, de);
                step();
                check32("rnd_full_load", 32'(mon_load - snap_load), 32'(LOAD_C));
                check32("rnd_full_en",   32'(mon_en - snap_en), 32'(LOAD_C + SPL_C));
                check32("rnd_full_done", 32'(mon_done - snap_done), 32'h1);
                check32("rnd_full_b", 32'(mon_b_en - snap_b), (fid == 0) ? 32'(LOAD_C + SPL_C) : 32'h0);
            end else begin
                k = int'($urandom_range(1, SPL_C - 1));
                avid_pulse();
                repeat (LOAD_C + k - 1) step();
                do_vsync(fid[0], 1'b0, 32'h0);
                check1 ("rnd_vs_en", a_en, 1'b0);
                check1 ("rnd_vs_err", a_err, 1'b1);
                step();
                check32("rnd_vs_en_cycles", 32'(mon_en - snap_en), 32'(LOAD_C + k));
                check32("rnd_vs_b", 32'(mon_b_en - snap_b), (fid == 0) ? 32'(LOAD_C + k) : 32'h0);
            end
            check32("rnd_seq_end", a_seq, m_active);
        end

        // Asynchronous reset in the middle of SHIFT.
        do_vsync(1'b0, 1'b0, 32'h0);
        lines(21, 1);
        avid_pulse();
        repeat (100) step();
        check1("pre_reset_en", a_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check1 ("async_en",    a_en,    1'b0);
        check1 ("async_load",  a_load,  1'b0);
        check32("async_seq",   a_seq,   32'h0);
        check1 ("async_ready", a_ready, 1'b1);
        check1 ("async_b_en",  b_en,    1'b0);
        m_full = 1'b0; m_active = 32'h0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
